data_mem_responder: RTL

// - Responder side of the CPU data-memory interface: serves one word load/store per request with LATENCY wait cycles.
// - Holds the MEM stage in place with a stall output; returns read data, a one-cycle completion pulse and an error flag.
// - Sits between the pipeline's MEM-stage request signals (address, read/write enables, store data) and word storage.

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_responder_word_array.sv | 22 ++
 rtl/data_mem_responder.sv | 100 ++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants, state encoding and request error check for the data-memory responder.
package data_mem_responder_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_BUSY = 2'd1,
    DMR_DONE = 2'd2
  } dmr_state_t;

  // A request is rejected if misaligned, outside storage, or asks for both a load and a store.
  function automatic logic req_error(input logic [31:0] addr,
                                     input logic        rd,
                                     input logic        wr,
                                     input logic [31:0] mem_bytes);
    return (addr[1:0] != 2'b00) || (addr >= mem_bytes) || (rd && wr);
  endfunction

endpackage

// File: rtl/data_mem_responder_word_array.sv
// Word storage: synchronous write, combinational read, contents are not reset.
module mem_word_array #(
  parameter int WORDS = 1024,
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:WORDS-1];

  // Store the word on the clock edge when the write enable is high.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: one word access per request after LATENCY wait cycles.
//   state    | meaning
//   DMR_IDLE | waiting; a visible request is latched and accepted
//   DMR_BUSY | counting down the latency; access performed when the counter reaches 0
//   DMR_DONE | completion pulse; the still-held request is not re-served
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_MEM_SIZE = 4096,
  parameter int LATENCY       = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] req_address,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_write_data,
  output logic [31:0] resp_read_data,
  output logic        resp_stall,
  output logic        resp_valid,
  output logic        resp_error
);

  localparam int WORDS = DATA_MEM_SIZE / WORD_BYTES;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
  localparam logic [31:0]   MEM_BYTES = 32'(DATA_MEM_SIZE);

  dmr_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_rd;
  logic        lat_wr;
  logic        lat_err;
  logic        access_now;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign lat_err    = req_error(lat_addr, lat_rd, lat_wr, MEM_BYTES);
  assign access_now = (state == DMR_BUSY) && (cnt == '0);
  assign mem_we     = access_now && lat_wr && !lat_err;
  assign resp_stall = ((state == DMR_IDLE) && (req_read || req_write)) || (state == DMR_BUSY);

  mem_word_array #(.WORDS(WORDS)) u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (lat_addr[AW+1:2]),
    .wdata (lat_data),
    .rdata (mem_rdata)
  );

  // Request FSM, latency counter, request latches and registered response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= DMR_IDLE;
      cnt            <= '0;
      lat_addr       <= '0;
      lat_data       <= '0;
      lat_rd         <= 1'b0;
      lat_wr         <= 1'b0;
      resp_read_data <= '0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
    end else begin
      case (state)
        DMR_IDLE: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          if (req_read || req_write) begin
            lat_addr <= req_address;
            lat_data <= req_write_data;
            lat_rd   <= req_read;
            lat_wr   <= req_write;
            cnt      <= CNT_LOAD;
            state    <= DMR_BUSY;
          end
        end
        DMR_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state      <= DMR_DONE;
            resp_valid <= 1'b1;
            resp_error <= lat_err;
            if (lat_rd) resp_read_data <= lat_err ? 32'h0 : mem_rdata;
          end
        end
        DMR_DONE: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          state      <= DMR_IDLE;
        end
        default: state <= DMR_IDLE;
      endcase
    end
  end

endmodule
